// File: rtl/systolic_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic job controller.
// The job sequence is IDLE -> LOAD_A -> LOAD_B -> CLR -> START -> WAIT -> STORE -> RESP.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CLR,
    S_START,
    S_WAIT,
    S_STORE,
    S_RESP
  } state_t;

  localparam int DEF_M = 8;
  localparam int DEF_N = 8;
  localparam int DEF_P = 8;

  localparam int DEF_ELEMS_A = DEF_M * DEF_N;
  localparam int DEF_ELEMS_B = DEF_N * DEF_P;
  localparam int DEF_ELEMS_C = DEF_M * DEF_P;

  function automatic int elem_count(input int rows, input int cols);
    return rows * cols;
  endfunction

  // A counter that must hold the value n itself needs clog2(n+1) bits.
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant scanning from pointer+1,
// with the pointer moving to the winner whenever a grant is accepted.
module rr_arbiter
  import systolic_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] ptr_q;
  int               idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  // Reset value NUM_REQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (accept && any) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/systolic_job_controller.sv
// Shares one systolic multiplier between requesters: fetches A/B from BRAM,
// runs the array, writes C back and signals completion to the job owner.
module systolic_job_controller
  import systolic_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int P          = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_a_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_b_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_c_base,
  output logic [NUM_REQ-1:0]            cmp_done,
  output logic                          cmp_err,
  output logic                          busy,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout,
  output logic                          mm_rst,
  output logic                          mm_start,
  output logic [M*N*DATA_WIDTH-1:0]     mm_matrix_a,
  output logic [N*P*DATA_WIDTH-1:0]     mm_matrix_b,
  input  logic                          mm_done,
  input  logic [M*P*DATA_WIDTH-1:0]     mm_result_c
);

  localparam int ELEMS_A = elem_count(M, N);
  localparam int ELEMS_B = elem_count(N, P);
  localparam int ELEMS_C = elem_count(M, P);
  localparam int KW      = cnt_bits(max3(ELEMS_A, ELEMS_B, ELEMS_C));
  localparam int TW      = cnt_bits(TIMEOUT);
  localparam int IDX_W   = idx_bits(NUM_REQ);

  state_t                        state_q, state_d;
  logic [KW-1:0]                 k_q;
  logic [KW-1:0]                 slot_p1;
  logic                          vld_p1;
  logic                          rd_p0;
  logic [TW-1:0]                 tmo_q;
  logic                          err_q;
  logic [IDX_W-1:0]              owner_q;
  logic [ADDR_WIDTH-1:0]         a_base_q, b_base_q, c_base_q;
  logic [M*N*DATA_WIDTH-1:0]     a_q;
  logic [N*P*DATA_WIDTH-1:0]     b_q;
  logic [M*P*DATA_WIDTH-1:0]     res_q;

  logic [NUM_REQ-1:0]            grant;
  logic [IDX_W-1:0]              grant_idx;
  logic                          grant_any;
  logic                          accept;
  logic                          last_a, last_b, last_c, tmo_hit;

  assign accept  = (state_q == S_IDLE) && grant_any;
  assign last_a  = (k_q == KW'(ELEMS_A));
  assign last_b  = (k_q == KW'(ELEMS_B));
  assign last_c  = (k_q == KW'(ELEMS_C - 1));
  assign tmo_hit = (tmo_q == TW'(TIMEOUT));

  assign busy        = (state_q != S_IDLE);
  assign mm_matrix_a = a_q;
  assign mm_matrix_b = b_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    cmp_done  = '0;
    cmp_err   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    mm_rst    = 1'b0;
    mm_start  = 1'b0;
    rd_p0     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = grant;
        if (grant_any) state_d = S_LOAD_A;
      end
      // The extra cycle at k == count issues no read; it only drains the capture pipe.
      S_LOAD_A: begin
        if (last_a) begin
          state_d = S_LOAD_B;
        end else begin
          rd_p0    = 1'b1;
          mem_addr = a_base_q + ADDR_WIDTH'(k_q);
        end
      end
      S_LOAD_B: begin
        if (last_b) begin
          state_d = S_CLR;
        end else begin
          rd_p0    = 1'b1;
          mem_addr = b_base_q + ADDR_WIDTH'(k_q);
        end
      end
      S_CLR: begin
        mm_rst  = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        mm_start = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (mm_done)      state_d = S_STORE;
        else if (tmo_hit) state_d = S_RESP;
      end
      S_STORE: begin
        mem_we   = 1'b1;
        mem_addr = c_base_q + ADDR_WIDTH'(k_q);
        mem_din  = res_q[int'(k_q)*DATA_WIDTH +: DATA_WIDTH];
        if (last_c) state_d = S_RESP;
      end
      S_RESP: begin
        cmp_done[owner_q] = 1'b1;
        cmp_err           = err_q;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      vld_p1   <= 1'b0;
      slot_p1  <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      owner_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= rd_p0;
      slot_p1 <= k_q;
      case (state_q)
        S_IDLE: begin
          k_q <= '0;
          if (accept) begin
            owner_q  <= grant_idx;
            a_base_q <= req_a_base[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            b_base_q <= req_b_base[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            c_base_q <= req_c_base[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
        S_LOAD_A: k_q <= last_a ? '0 : k_q + 1'b1;
        S_LOAD_B: k_q <= last_b ? '0 : k_q + 1'b1;
        S_START: begin
          k_q   <= '0;
          tmo_q <= '0;
        end
        S_WAIT: begin
          if (!mm_done) begin
            if (tmo_hit) err_q <= 1'b1;
            else         tmo_q <= tmo_q + 1'b1;
          end
        end
        S_STORE: k_q <= k_q + 1'b1;
        S_RESP:  err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---- p1: BRAM read data returns one cycle after its address ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      if (vld_p1 && state_q == S_LOAD_A) a_q[int'(slot_p1)*DATA_WIDTH +: DATA_WIDTH] <= mem_dout;
      if (vld_p1 && state_q == S_LOAD_B) b_q[int'(slot_p1)*DATA_WIDTH +: DATA_WIDTH] <= mem_dout;
      if (state_q == S_WAIT && mm_done)  res_q <= mm_result_c;
    end
  end

endmodule

// File: tb/tb_systolic_job_controller.sv
// Bench for systolic_job_controller with a behavioural BRAM, an accumulating
// multiplier model and a write scoreboard of expected C stores.
module tb_systolic_job_controller;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int NR = 2;
  localparam int TMO = 255;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_ready;
  logic [NR*AW-1:0]    req_a_base = '0;
  logic [NR*AW-1:0]    req_b_base = '0;
  logic [NR*AW-1:0]    req_c_base = '0;
  logic [NR-1:0]       cmp_done;
  logic                cmp_err;
  logic                busy;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_din;
  logic [DW-1:0]       mem_dout;
  logic                mm_rst;
  logic                mm_start;
  logic [64*DW-1:0]    mm_matrix_a;
  logic [64*DW-1:0]    mm_matrix_b;
  logic                mm_done = 1'b0;
  logic [64*DW-1:0]    mm_result_c;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_w;

  logic [DW-1:0] bram [1024];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  logic [DW-1:0] acc [64];
  int            mm_cnt = 0;
  bit            mm_enable = 1'b1;

  systolic_job_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a_base  (req_a_base),
    .req_b_base  (req_b_base),
    .req_c_base  (req_c_base),
    .cmp_done    (cmp_done),
    .cmp_err     (cmp_err),
    .busy        (busy),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mm_rst      (mm_rst),
    .mm_start    (mm_start),
    .mm_matrix_a (mm_matrix_a),
    .mm_matrix_b (mm_matrix_b),
    .mm_done     (mm_done),
    .mm_result_c (mm_result_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)       bram[pl_addr] <= pl_data;
    else if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  function automatic logic [DW-1:0] dot(input int i, input int j);
    logic [DW-1:0] s;
    s = '0;
    for (int n = 0; n < 8; n++)
      s = s + mm_matrix_a[(i*8+n)*DW +: DW] * mm_matrix_b[(n*8+j)*DW +: DW];
    return s;
  endfunction

  // Accumulates like a real array: only mm_rst clears the accumulators.
  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (mm_rst)
      for (int k = 0; k < 64; k++) acc[k] <= '0;
    if (mm_start) begin
      mm_cnt <= 12;
    end else if (mm_cnt > 0) begin
      mm_cnt <= mm_cnt - 1;
      if (mm_cnt == 1 && mm_enable) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            acc[i*8+j] <= acc[i*8+j] + dot(i, j);
        mm_done <= 1'b1;
      end
    end
  end

  always_comb begin
    mm_result_c = '0;
    for (int k = 0; k < 64; k++) mm_result_c[k*DW +: DW] = acc[k];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%0d (no write expected)", mem_addr, mem_din);
      end else begin
        mon_w = exp_q.pop_front();
        if (mem_addr !== mon_w.addr || mem_din !== mon_w.data) begin
          errors++;
          $display("FAIL store addr=%0d data=%0d, expected addr=%0d data=%0d",
                   mem_addr, mem_din, mon_w.addr, mon_w.data);
        end
      end
    end
  end

  task automatic preload(input int addr, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = AW'(addr);
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic push_exp(input int c_base, input int k, input logic [DW-1:0] d);
    wr_t w;
    w.addr = AW'(c_base + k);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic set_bases(input int r, input int a, input int b, input int c);
    req_a_base[r*AW +: AW] = AW'(a);
    req_b_base[r*AW +: AW] = AW'(b);
    req_c_base[r*AW +: AW] = AW'(c);
  endtask

  task automatic wait_accept(output logic [NR-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if ((req_ready & req_valid) != '0) begin
        g  = req_ready & req_valid;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic wait_cmp(output logic [NR-1:0] done, output logic err,
                          output int cycles, output bit ok);
    done = '0; err = 1'b0; cycles = 0; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cycles++;
      if (cmp_done != '0) begin
        done = cmp_done;
        err  = cmp_err;
        ok   = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_job(input int r, input int a, input int b, input int c,
                         output logic [NR-1:0] done, output logic err,
                         output int cycles, output bit ok);
    logic [NR-1:0] g;
    set_bases(r, a, b, c);
    req_valid[r] = 1'b1;
    wait_accept(g, ok);
    req_valid[r] = 1'b0;
    done = '0; err = 1'b0; cycles = 0;
    if (ok) wait_cmp(done, err, cycles, ok);
  endtask

  task automatic load_identity_and_b();
    for (int k = 0; k < 64; k++) preload(k, (k / 8 == k % 8) ? 8'd1 : 8'd0);
    for (int k = 0; k < 64; k++) preload(64 + k, DW'(k + 1));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL reset_mem we=%0b addr=%0d want 0/0", mem_we, mem_addr);
    end
    vectors++;
    if (mm_start !== 1'b0 || mm_rst !== 1'b0) begin
      errors++; $display("FAIL reset_mm start=%0b rst=%0b want 0/0", mm_start, mm_rst);
    end
    vectors++;
    if (cmp_done !== '0 || cmp_err !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_resp done=%b err=%b ready=%b want 0", cmp_done, cmp_err, req_ready);
    end
    vectors++;
    if (mm_matrix_a !== '0 || mm_matrix_b !== '0) begin
      errors++; $display("FAIL reset_operands nonzero, want 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [NR-1:0] g, done, want;
    logic err;
    int cyc;
    bit ok;
    load_identity_and_b();
    set_bases(0, 0, 64, 128);
    set_bases(1, 0, 64, 256);
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      want = (j % 2 == 0) ? 2'b01 : 2'b10;
      wait_accept(g, ok);
      if (j == 3) req_valid = '0;
      vectors++;
      if (!ok || g !== want) begin
        errors++; $display("FAIL arb_grant_%0d got=%b want=%b ok=%0b", j, g, want, ok);
      end
      for (int k = 0; k < 64; k++) push_exp((want == 2'b01) ? 128 : 256, k, DW'(k + 1));
      wait_cmp(done, err, cyc, ok);
      vectors++;
      if (!ok || done !== want || err !== 1'b0) begin
        errors++; $display("FAIL arb_done_%0d got=%b err=%b want=%b err=0", j, done, err, want);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || bram[128] !== 8'd1 || bram[191] !== 8'd64) begin
      errors++;
      $display("FAIL arb_result pending=%0d c0=%0d c63=%0d want 0/1/64", exp_q.size(), bram[128], bram[191]);
    end
  endtask

  task automatic test_single_job();
    logic [NR-1:0] done;
    logic err;
    int cyc;
    bit ok;
    for (int k = 0; k < 64; k++) push_exp(128, k, DW'(k + 1));
    run_job(0, 0, 64, 128, done, err, cyc, ok);
    vectors++;
    if (!ok || done !== 2'b01 || err !== 1'b0) begin
      errors++; $display("FAIL single_done got=%b err=%b ok=%0b want=01 err=0", done, err, ok);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL single_writes pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] done;
    logic err;
    int cyc;
    bit ok;
    for (int k = 0; k < 64; k++) preload(300 + k, 8'd1);
    for (int k = 0; k < 64; k++) preload(400 + k, 8'd2);
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 64; k++) push_exp(500 + 100*j, k, 8'd16);
      run_job(1, 300, 400, 500 + 100*j, done, err, cyc, ok);
      vectors++;
      if (!ok || done !== 2'b10 || err !== 1'b0) begin
        errors++; $display("FAIL b2b_done_%0d got=%b err=%b want=10 err=0", j, done, err);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || bram[663] !== 8'd16) begin
      errors++; $display("FAIL b2b_result pending=%0d c63=%0d want 0/16", exp_q.size(), bram[663]);
    end
  endtask

  task automatic test_timeout();
    logic [NR-1:0] done;
    logic err;
    int cyc;
    bit ok;
    mm_enable = 1'b0;
    run_job(0, 0, 64, 800, done, err, cyc, ok);
    mm_enable = 1'b1;
    vectors++;
    if (!ok || done !== 2'b01 || err !== 1'b1) begin
      errors++; $display("FAIL timeout_resp got=%b err=%b want=01 err=1", done, err);
    end
    vectors++;
    if (cyc < TMO) begin
      errors++; $display("FAIL timeout_wait cycles=%0d want>=%0d", cyc, TMO);
    end
    @(negedge clk);
    vectors++;
    if (cmp_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_clear err=%b busy=%b want 0/0", cmp_err, busy);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [NR-1:0] g, done;
    logic err;
    int cyc, pulses;
    bit ok, hit;
    for (int k = 0; k <= 10; k++) push_exp(900, k, DW'(k + 1));
    set_bases(0, 0, 64, 900);
    req_valid[0] = 1'b1;
    wait_accept(g, ok);
    req_valid[0] = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == AW'(910)) begin hit = 1'b1; break; end
    end
    vectors++;
    if (!ok || !hit) begin
      errors++; $display("FAIL midreset_reach ok=%0b hit=%0b want 1/1", ok, hit);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mm_start !== 1'b0) begin
      errors++; $display("FAIL midreset_drop we=%b busy=%b start=%b want 0", mem_we, busy, mm_start);
    end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (cmp_done != '0) pulses++; end
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); if (cmp_done != '0) pulses++; end
    vectors++;
    if (pulses != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL midreset_quiet pulses=%0d pending=%0d want 0/0", pulses, exp_q.size());
    end
    for (int k = 0; k < 64; k++) push_exp(900, k, DW'(k + 1));
    run_job(0, 0, 64, 900, done, err, cyc, ok);
    vectors++;
    if (!ok || done !== 2'b01 || err !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL midreset_next got=%b err=%b pending=%0d want=01 err=0 0", done, err, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [NR-1:0] done;
    logic err;
    int cyc;
    bit ok;
    for (int k = 0; k < 64; k++) preload((1020 + k) % 1024, (k / 8 == k % 8) ? 8'd2 : 8'd0);
    for (int k = 0; k < 64; k++) push_exp(700, k, DW'(2 * (k + 1)));
    run_job(1, 1020, 64, 700, done, err, cyc, ok);
    vectors++;
    if (!ok || done !== 2'b10 || err !== 1'b0) begin
      errors++; $display("FAIL wrap_done got=%b err=%b want=10 err=0", done, err);
    end
    vectors++;
    if (exp_q.size() != 0 || bram[763] !== 8'd128) begin
      errors++; $display("FAIL wrap_result pending=%0d c63=%0d want 0/128", exp_q.size(), bram[763]);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single_job();
    test_back_to_back();
    test_timeout();
    test_reset_mid_store();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/systolic_job_controller.md
Name: systolic_job_controller

Overview:
Shares one systolic matrix multiplier between NUM_REQ requesters and sequences each job end to end. Arbitrates round-robin and fetches A and B row-major from a single-port synchronous BRAM into packed operand registers. Then clears the array, pulses start, waits for done and writes the result matrix back to BRAM. Sits between the host-side command ports and the multiplier/BRAM pair.

Parameters:
DATA_WIDTH, 8, element width (BRAM word = one element)
M, 8, rows of A / C
N, 8, cols of A / rows of B
P, 8, cols of B / C
ADDR_WIDTH, 10, BRAM address width
NUM_REQ, 2, number of requesters
TIMEOUT, 255, max cycles spent in WAIT before abort

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  job request per requester; held until accepted
req_ready  out  NUM_REQ  acceptance; job taken when valid&&ready
req_a_base  in  NUM_REQ*ADDR_WIDTH  per-requester A base address (slice i)
req_b_base  in  NUM_REQ*ADDR_WIDTH  B base address
req_c_base  in  NUM_REQ*ADDR_WIDTH  C base address
cmp_done  out  NUM_REQ  one-cycle completion pulse to job owner
cmp_err  out  1  high with cmp_done when job timed out
busy  out  1  high in every state except IDLE
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_WIDTH  BRAM address
mem_din  out  DATA_WIDTH  BRAM write data
mem_dout  in  DATA_WIDTH  BRAM read data, valid one cycle after address
mm_rst  out  1  active-high clear to multiplier (PE accumulators)
mm_start  out  1  multiplier start
mm_matrix_a  out  M*N*DATA_WIDTH  packed A, element k at bits k*DATA_WIDTH
mm_matrix_b  out  N*P*DATA_WIDTH  packed B
mm_done  in  1  multiplier done pulse
mm_result_c  in  M*P*DATA_WIDTH  packed C

Behaviour:
- Reset: state IDLE, all outputs 0, operand/result registers 0, element counter 0, RR pointer NUM_REQ-1 (requester 0 wins first).
- States: IDLE, LOAD_A, LOAD_B, CLR, START, WAIT, STORE, RESP.
- IDLE: grant = first valid requester scanning from pointer+1 (wrap). req_ready[grant] combinational, only in IDLE. On acceptance: latch bases and owner, pointer<=owner, go LOAD_A.
- LOAD_A: one read per cycle, addr = a_base+k, k=0..M*N-1; mem_dout captured next cycle into slot k. Exits after last capture, M*N+1 cycles in state. LOAD_B identical with b_base and N*P elements.
- mem_dout capture is pipelined: a valid-delay flag marks capture cycles; no read issued on final cycle.
- Address sums wrap modulo 2^ADDR_WIDTH.
- CLR: mm_rst=1 for exactly one cycle (accumulators only clear on reset). START: mm_start=1 for exactly one cycle, timeout counter cleared.
- WAIT: on mm_done, register mm_result_c, go STORE. Counter reaching TIMEOUT: err flag set, skip to RESP.
- mm_done outside WAIT is ignored.
- STORE: mem_we=1 for M*P consecutive cycles, addr c_base+k, din = result element k.
- RESP: cmp_done[owner]=1 and cmp_err=err for one cycle; clear err, go IDLE. New acceptance possible the following cycle.
- mm_matrix_a/b driven from registers, stable from START until next job's LOAD.
- Requests arriving during busy wait; no queueing beyond held valid.
- Reset mid-job: immediate abort to reset values, no cmp_done, no further BRAM writes.

Decomposition:
- Package systolic_ctrl_pkg: state encoding constants, element-count constants (M*N, N*P, M*P), counter width.
- Sub-module rr_arbiter (NUM_REQ, combinational grant from valid and pointer, registered pointer update on accept).

Test Plan:
- BRAM A=identity at 0, B=1..64 at 64, req0 c_base 128 -> cmp_done[0] pulse; BRAM[128..191]=1..64; cmp_err=0.
- req0 and req1 valid same cycle -> req0 accepted first, req1 second; with both held continuously, grants alternate 0,1,0,1.
- Two back-to-back jobs, A=all 1, B=all 2, N=8 -> second result all 16, not 32 (mm_rst pulse verified).
- a_base=1020, ADDR_WIDTH=10 -> reads wrap to addresses 1020..1023,0..59; result correct.
- mm_done never asserted -> after TIMEOUT cycles cmp_done with cmp_err=1, no mem_we pulses.
- rst_n low during STORE at k=10 -> mem_we, busy, mm_start drop immediately; no cmp_done; next job completes normally.
